program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Write-side initiator for the MIPS program memory: erases it through the memory's active-low soft_reset / o_reset_ack handshake, then fills it with words assembled from a byte stream.
- The byte stream comes from the debug unit's UART receiver.
- Sits between the debug unit and the program memory's write port (i_addr, i_data, wea, ena).
- Reports done when a HALT word has been stored, or error when memory overflows.

Parameters:
- RAM_WIDTH, 32, memory word width in bits; must be a multiple of 8.
- RAM_DEPTH, 2048, memory depth in words.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is stored in memory and terminates the load.
- Derived localparams: ADDR_WIDTH = clogb2(RAM_DEPTH) = 12 at defaults; BYTES_PER_WORD = RAM_WIDTH/8.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  pulse: erase memory then load; honoured in IDLE, DONE and ERROR only.
- i_byte  in  8  byte from the UART receiver.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  loader accepts a byte this cycle.
- i_reset_ack  in  1  from the memory's o_reset_ack; 0 = erase finished.
- o_soft_reset  out  1  to the memory's soft_reset; active-low erase request.
- o_addr  out  ADDR_WIDTH  memory write address.
- o_data  out  RAM_WIDTH  memory write data.
- o_ena  out  1  memory enable.
- o_wea  out  1  memory write enable.
- o_word_count  out  ADDR_WIDTH+1  number of words written, including HALT.
- o_busy  out  1  high in CLEAR, LOAD and WRITE.
- o_done  out  1  HALT word stored.
- o_error  out  1  memory filled with no HALT word.

Behaviour:
- Reset values: state IDLE, o_soft_reset=1, o_byte_ready=0, o_ena=0, o_wea=0, o_addr=0, o_data=0, o_word_count=0, o_busy=0, o_done=0, o_error=0; internal byte counter and word buffer cleared.
- Reset mid-operation: returns to IDLE immediately. Memory contents are untouched except that an erase in progress stops, because o_soft_reset returns to 1.
- All outputs are registered, or decoded from the state register.
- IDLE: o_soft_reset=1. On i_start go to CLEAR and clear o_word_count.
- CLEAR:
  - Drive o_soft_reset=0.
  - The first cycle in CLEAR ignores i_reset_ack, because the memory's ack is registered and still reads 1.
  - From the second cycle on, i_reset_ack==0 -> go to LOAD with address=0 and byte counter=0.
  - No timeout.
- LOAD:
  - o_byte_ready=1.
  - Each cycle with i_byte_valid & o_byte_ready accepts one byte, packed MSB-first: the first byte lands in bits [RAM_WIDTH-1:RAM_WIDTH-8], i.e. {buf[RAM_WIDTH-9:0], i_byte}.
  - Accepting byte BYTES_PER_WORD -> go to WRITE and drop o_byte_ready in the same edge.
  - Back-to-back bytes are allowed.
- WRITE:
  - Exactly one cycle with o_ena=1, o_wea=1, o_addr=address, o_data=word; o_byte_ready=0.
  - o_word_count increments.
  - Word == HALT_WORD -> DONE.
  - Otherwise, address == RAM_DEPTH-1 -> ERROR.
  - Otherwise address+1 -> LOAD.
  - The address never wraps.
- DONE: o_done=1, o_busy=0, o_soft_reset=1, port idle. i_start -> CLEAR (reload).
- ERROR: o_error=1, otherwise the same as DONE. i_start -> CLEAR.
- Outside WRITE: o_ena=0 and o_wea=0.
- i_start in CLEAR, LOAD or WRITE is ignored.
- Byte counter width is clogb2(BYTES_PER_WORD); the partial word is discarded on leaving LOAD by reset.
- Latency: a word's 4th accepted byte -> memory write on the next cycle. The next byte is accepted one cycle after WRITE.
- HALT as the last slot: a HALT written at address RAM_DEPTH-1 gives DONE, not ERROR.

Decomposition:
- Shared package (mips_pkg):
  - loader state encoding (IDLE, CLEAR, LOAD, WRITE, DONE, ERROR; 3 bits)
  - HALT_WORD default
  - the clogb2 function, already used by the memory
- Sub-module word_assembler:
  - byte shift register and byte counter
  - inputs: clear, byte strobe
  - outputs: word, word_complete
- The FSM and address/word counters stay in program_loader.

Test Plan:
- Erase handshake: i_start; memory model holds i_reset_ack=1 for 5 cycles then 0 -> o_soft_reset low for exactly 6 cycles; o_byte_ready rises the cycle after the ack reads 0.
- Two-word load: bytes 12 34 56 78 AB CD EF 01 then FF FF FF FF -> writes 32'h12345678@0, 32'hABCDEF01@1 and HALT@2, each with a single-cycle wea; o_word_count=3; o_done=1.
- Valid gaps: random i_byte_valid gaps over 3 words + HALT -> identical memory image; no extra or duplicate writes.
- Overflow: RAM_DEPTH=8, 8 non-HALT words -> last write @7, then o_error=1, o_done=0, no 9th write; a HALT written as the 8th word instead gives o_done=1.
- Reset mid-LOAD: i_reset after 2 bytes of word 1 -> outputs return to reset values asynchronously. Then i_start plus a full reload gives a correct image starting @0, with no stale bytes in the buffer.
- Restart from DONE: i_start -> CLEAR reasserted; i_start during LOAD -> ignored (no soft_reset pulse).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program-memory side: loader state encoding,
// the default end-of-program marker and the clogb2 width helper.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Number of bits needed to hold the value depth (2048 -> 12, 8 -> 4).
    function automatic int clogb2(input int depth);
        int r;
        int d;
        r = 0;
        d = depth;
        while (d > 0) begin
            r = r + 1;
            d = d >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream from the UART receiver plus the program memory's erase handshake
// and write port, as seen from the loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int RAM_WIDTH  = 32
);
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic                  i_reset_ack;
    logic                  o_soft_reset;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [RAM_WIDTH-1:0]  o_data;
    logic                  o_ena;
    logic                  o_wea;

    modport master (
        input  i_byte, i_byte_valid, i_reset_ack,
        output o_byte_ready, o_soft_reset, o_addr, o_data, o_ena, o_wea
    );

    modport slave (
        output i_byte, i_byte_valid, i_reset_ack,
        input  o_byte_ready, o_soft_reset, o_addr, o_data, o_ena, o_wea
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes MSB-first into a memory word and flags the strobe that
// completes it.
module program_loader_word_assembler
    import mips_pkg::*;
#(
    parameter int RAM_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_strobe,
    input  logic [7:0]           i_byte,
    output logic [RAM_WIDTH-1:0] o_word,
    output logic                 o_word_complete
);
    localparam int BYTES_PER_WORD = RAM_WIDTH / 8;
    localparam int CNT_W          = clogb2(BYTES_PER_WORD);

    logic [RAM_WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign o_word          = word_q;
    assign o_word_complete = i_strobe && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_strobe) begin
            word_d = {word_q[RAM_WIDTH-9:0], i_byte};
            cnt_d  = o_word_complete ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Erases the program memory, then fills it word by word from the UART byte
// stream until a HALT word is stored (done) or the memory is full (error).
//
// state | meaning
// IDLE  | waiting for i_start, memory untouched
// CLEAR | soft_reset low, waiting for the memory's ack to drop
// LOAD  | accepting bytes into the word assembler
// WRITE | one-cycle write of the assembled word
// DONE  | HALT word stored
// ERROR | memory filled without a HALT word
module program_loader
    import mips_pkg::*;
#(
    parameter int                   RAM_WIDTH = 32,
    parameter int                   RAM_DEPTH = 2048,
    parameter logic [RAM_WIDTH-1:0] HALT_WORD = RAM_WIDTH'(HALT_WORD_DEFAULT)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    program_loader_if.master           bus,
    output logic [clogb2(RAM_DEPTH):0] o_word_count,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);
    localparam int ADDR_WIDTH = clogb2(RAM_DEPTH);

    loader_state_e         state_q, state_d;
    logic                  clear_first_q, clear_first_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;

    logic                 asm_strobe;
    logic [RAM_WIDTH-1:0] asm_word;
    logic                 asm_complete;

    assign asm_strobe = bus.i_byte_valid && (state_q == ST_LOAD);

    program_loader_word_assembler #(
        .RAM_WIDTH(RAM_WIDTH)
    ) u_word_assembler (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clear         (state_q == ST_CLEAR),
        .i_strobe        (asm_strobe),
        .i_byte          (bus.i_byte),
        .o_word          (asm_word),
        .o_word_complete (asm_complete)
    );

    always_comb begin
        state_d       = state_q;
        clear_first_d = clear_first_q;
        addr_d        = addr_q;
        word_count_d  = word_count_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d       = ST_CLEAR;
                    clear_first_d = 1'b1;
                    word_count_d  = '0;
                end
            end
            ST_CLEAR: begin
                // The memory's ack is registered and still reads 1 on entry.
                clear_first_d = 1'b0;
                if (!clear_first_q && !bus.i_reset_ack) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end
            ST_LOAD: begin
                if (asm_complete) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_count_d = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                if (asm_word == HALT_WORD) begin
                    state_d = ST_DONE;
                end else if (addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            clear_first_q <= 1'b0;
            addr_q        <= '0;
            word_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            clear_first_q <= clear_first_d;
            addr_q        <= addr_d;
            word_count_q  <= word_count_d;
        end
    end

    assign bus.o_soft_reset = (state_q != ST_CLEAR);
    assign bus.o_byte_ready = (state_q == ST_LOAD);
    assign bus.o_ena        = (state_q == ST_WRITE);
    assign bus.o_wea        = (state_q == ST_WRITE);
    assign bus.o_addr       = addr_q;
    assign bus.o_data       = asm_word;
    assign o_word_count     = word_count_q;
    assign o_busy           = (state_q == ST_CLEAR) || (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign o_done           = (state_q == ST_DONE);
    assign o_error          = (state_q == ST_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader with an 8-word memory model: erase handshake,
// table-driven word loads, overflow, HALT in the last slot and mid-load reset.
module tb_program_loader;
    import mips_pkg::*;

    localparam int AW = 4;  // clogb2(8)

    typedef struct {
        logic [31:0] word;
        int          gap;
        bit          rnd;
        int          exp_addr;
        int          exp_wc;
        bit          exp_ready;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   wc;
    logic          busy, done, error;

    program_loader_if #(.ADDR_WIDTH(AW), .RAM_WIDTH(32)) bus ();

    program_loader #(
        .RAM_WIDTH (32),
        .RAM_DEPTH (8),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .bus          (bus),
        .o_word_count (wc),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [8];
    int          wr_count = 0;
    int          ack_cnt = 0;
    int          wea_multi = 0;
    logic        prev_wea = 1'b0;

    // Memory model: registered ack drops after five cycles of soft_reset low.
    always @(posedge clk) begin
        if (!bus.o_soft_reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
            ack_cnt         <= ack_cnt + 1;
            bus.i_reset_ack <= (ack_cnt + 1 < 5);
        end else begin
            ack_cnt         <= 0;
            bus.i_reset_ack <= 1'b1;
        end
        if (bus.o_ena && bus.o_wea) begin
            mem[bus.o_addr[2:0]] <= bus.o_data;
            wr_count             <= wr_count + 1;
        end
        if (bus.o_wea && prev_wea) wea_multi <= wea_multi + 1;
        prev_wea <= bus.o_wea;
    end

    int   checks = 0;
    int   errors = 0;
    vec_t tab [8];
    int   n_vec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_soft_reset"}, bus.o_soft_reset, 1);
        chk({tag, "_byte_ready"}, bus.o_byte_ready, 0);
        chk({tag, "_ena"}, bus.o_ena, 0);
        chk({tag, "_wea"}, bus.o_wea, 0);
        chk({tag, "_addr"}, bus.o_addr, 0);
        chk({tag, "_data"}, bus.o_data, 0);
        chk({tag, "_word_count"}, wc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic do_start(input string tag);
        int   lowcnt;
        int   t;
        logic ack_before;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lowcnt = 0;
        t = 0;
        ack_before = 1'bx;
        while (!bus.o_byte_ready && t < 100) begin
            if (!bus.o_soft_reset) lowcnt++;
            ack_before = bus.i_reset_ack;
            @(negedge clk);
            t++;
        end
        chk({tag, "_reached_load"}, bus.o_byte_ready, 1);
        chk({tag, "_soft_low_cycles"}, lowcnt, 6);
        chk({tag, "_ack_before_ready"}, ack_before, 0);
        chk({tag, "_wc_cleared"}, wc, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) begin
            bus.i_byte_valid = 1'b0;
            @(negedge clk);
        end
        while (!bus.o_byte_ready && t < 50) begin
            bus.i_byte_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!bus.o_byte_ready) chk("byte_ready_timeout", bus.o_byte_ready, 1);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input vec_t v);
        int g;
        for (int k = 0; k < 4; k++) begin
            g = v.rnd ? int'($urandom_range(0, 3)) : v.gap;
            send_byte(v.word[31-8*k -: 8], g);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < n_vec; i++) begin
            send_word(tab[i]);
            chk($sformatf("%s_w%0d_ena", tag, i), bus.o_ena, 1);
            chk($sformatf("%s_w%0d_wea", tag, i), bus.o_wea, 1);
            chk($sformatf("%s_w%0d_addr", tag, i), bus.o_addr, tab[i].exp_addr);
            chk($sformatf("%s_w%0d_data", tag, i), bus.o_data, tab[i].word);
            chk($sformatf("%s_w%0d_ready_low", tag, i), bus.o_byte_ready, 0);
            bus.i_byte_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_w%0d_next_ready", tag, i), bus.o_byte_ready, tab[i].exp_ready);
            chk($sformatf("%s_w%0d_wc", tag, i), wc, tab[i].exp_wc);
            chk($sformatf("%s_w%0d_ena_off", tag, i), bus.o_ena, 0);
        end
    endtask

    task automatic load_two_words();
        tab[0] = '{32'h1234_5678, 0, 1'b0, 0, 1, 1'b1};
        tab[1] = '{32'hABCD_EF01, 0, 1'b0, 1, 2, 1'b1};
        tab[2] = '{32'hFFFF_FFFF, 0, 1'b0, 2, 3, 1'b0};
        n_vec  = 3;
    endtask

    initial begin
        int base;
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        #3;
        check_reset_vals("reset");
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Erase handshake and two-word load with HALT.
        do_start("start1");
        load_two_words();
        base = wr_count;
        run_table("two");
        chk("two_done", done, 1);
        chk("two_error", error, 0);
        chk("two_busy", busy, 0);
        chk("two_wc", wc, 3);
        chk("two_soft", bus.o_soft_reset, 1);
        chk("two_mem0", mem[0], 32'h1234_5678);
        chk("two_mem1", mem[1], 32'hABCD_EF01);
        chk("two_mem2", mem[2], 32'hFFFF_FFFF);
        chk("two_writes", wr_count - base, 3);

        // Restart from DONE, random valid gaps.
        do_start("restart_done");
        tab[0] = '{32'hCAFE_F00D, 0, 1'b1, 0, 1, 1'b1};
        tab[1] = '{32'h0BAD_BEEF, 0, 1'b1, 1, 2, 1'b1};
        tab[2] = '{32'h0001_0203, 0, 1'b1, 2, 3, 1'b1};
        tab[3] = '{32'hFFFF_FFFF, 0, 1'b1, 3, 4, 1'b0};
        n_vec  = 4;
        base = wr_count;
        run_table("gaps");
        chk("gaps_done", done, 1);
        chk("gaps_mem0", mem[0], 32'hCAFE_F00D);
        chk("gaps_mem1", mem[1], 32'h0BAD_BEEF);
        chk("gaps_mem2", mem[2], 32'h0001_0203);
        chk("gaps_mem3", mem[3], 32'hFFFF_FFFF);
        chk("gaps_mem4_erased", mem[4], 32'h0);
        chk("gaps_writes", wr_count - base, 4);

        // Overflow: eight non-HALT words fill the memory.
        do_start("overflow");
        for (int i = 0; i < 8; i++)
            tab[i] = '{32'h1111_1111 * (i + 1), 0, 1'b0, i, i + 1, (i != 7)};
        n_vec = 8;
        base = wr_count;
        run_table("ovf");
        repeat (5) @(negedge clk);
        chk("ovf_error", error, 1);
        chk("ovf_done", done, 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_wc", wc, 8);
        chk("ovf_writes", wr_count - base, 8);
        chk("ovf_mem7", mem[7], 32'h8888_8888);

        // HALT in the last slot, plus i_start ignored while in LOAD.
        do_start("halt_last");
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ign_start_soft%0d", i), bus.o_soft_reset, 1);
            chk($sformatf("ign_start_ready%0d", i), bus.o_byte_ready, 1);
            @(negedge clk);
        end
        for (int i = 0; i < 7; i++)
            tab[i] = '{32'hA000_0000 + i, 0, 1'b0, i, i + 1, 1'b1};
        tab[7] = '{32'hFFFF_FFFF, 0, 1'b0, 7, 8, 1'b0};
        n_vec  = 8;
        run_table("hl");
        chk("hl_done", done, 1);
        chk("hl_error", error, 0);
        chk("hl_wc", wc, 8);
        chk("hl_mem0", mem[0], 32'hA000_0000);
        chk("hl_mem7", mem[7], 32'hFFFF_FFFF);

        // Reset after two bytes of a word, then a clean reload.
        do_start("pre_reset");
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rst = 1'b1;
        #1;
        check_reset_vals("midload");
        bus.i_byte_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        do_start("reload");
        load_two_words();
        base = wr_count;
        run_table("reload");
        chk("reload_mem0", mem[0], 32'h1234_5678);
        chk("reload_mem1", mem[1], 32'hABCD_EF01);
        chk("reload_mem2", mem[2], 32'hFFFF_FFFF);
        chk("reload_writes", wr_count - base, 3);
        chk("reload_done", done, 1);

        chk("wea_single_cycle", wea_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
